mem_arbiter: RTL and testbench

Single-port memory arbiter for the 8-bit CPU. It shares one 1K×8 memory between the instruction-fetch port and the control unit's data load/store port. The data port has fixed priority, with a starvation guard for fetch, and the arbiter inserts the memory's read wait states. It sits between the control unit and the memory, replacing direct drive of the memory address and write-enable from the control unit.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the memory arbiter.
// Holds the default memory geometry, the arbiter state encoding and the
// access-owner encoding.
package cpu_pkg;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: shares one memory between instruction fetch and
// the data load/store port. Data has priority; fetch is forced through after
// STARVE_MAX data grants taken while fetch was waiting. Read accesses hold the
// memory for MEM_LAT cycles, stores for one; every access ends with a one-cycle
// response so there is never a back-to-back grant.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   if_req/if_addr              fetch request (held until if_gnt)
//   if_gnt/if_valid/if_rdata    fetch grant pulse, data-valid pulse, fetched byte
//   d_req/d_we/d_addr/d_wdata   data request (held until d_gnt), 1 = store
//   d_gnt/d_valid/d_rdata       data grant pulse, completion pulse, loaded byte
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_rdata         memory side; address/wdata are 0 outside ACCESS
//   busy                        arbiter not IDLE
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned WaitW   = 3;
  localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);
  localparam logic [WaitW-1:0]   WaitInit  = WaitW'(MEM_LAT - 1);
  localparam logic [StarveW-1:0] StarveSat = StarveW'(STARVE_MAX);

  if (MEM_LAT == 0 || MEM_LAT > 8) begin : g_bad_lat
    $error("mem_arbiter: MEM_LAT must be in 1..8");
  end
  if (STARVE_MAX == 0) begin : g_bad_starve
    $error("mem_arbiter: STARVE_MAX must be at least 1");
  end

  arb_state_e          r_state, w_state_next;
  owner_e              r_owner;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic [DATA_W-1:0]   r_wdata;
  logic [WaitW-1:0]    r_wait;
  logic [StarveW-1:0]  r_starve;
  logic                r_if_gnt, r_d_gnt, r_if_valid, r_d_valid;
  logic [DATA_W-1:0]   r_if_rdata, r_d_rdata;

  logic w_any_req, w_pick_if, w_last, w_grant, w_finish;

  assign w_any_req = if_req | d_req;
  // Fetch only beats a pending data request once it has been passed over
  // STARVE_MAX times in a row.
  assign w_pick_if = if_req & (~d_req | (r_starve == StarveSat));
  // A store needs a single cycle; reads run the wait counter down to zero.
  assign w_last    = r_we | (r_wait == '0);
  assign w_grant   = (r_state == IDLE) & w_any_req;
  assign w_finish  = (r_state == ACCESS) & w_last;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_any_req) w_state_next = ACCESS;
      ACCESS:  if (w_last) w_state_next = RESP;
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner    <= OWN_IF;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_wait     <= '0;
      r_starve   <= '0;
      r_if_gnt   <= 1'b0;
      r_d_gnt    <= 1'b0;
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_if_gnt   <= w_grant & w_pick_if;
      r_d_gnt    <= w_grant & ~w_pick_if;
      r_if_valid <= w_finish & (r_owner == OWN_IF);
      r_d_valid  <= w_finish & (r_owner == OWN_D);
      if (w_grant) begin
        r_owner <= w_pick_if ? OWN_IF : OWN_D;
        r_addr  <= w_pick_if ? if_addr : d_addr;
        r_we    <= ~w_pick_if & d_we;
        r_wdata <= w_pick_if ? '0 : d_wdata;
        r_wait  <= WaitInit;
        if (w_pick_if) begin
          r_starve <= '0;
        end else if (if_req && (r_starve != StarveSat)) begin
          r_starve <= r_starve + 1'b1;
        end
      end else if ((r_state == ACCESS) && !w_last) begin
        r_wait <= r_wait - 1'b1;
      end
      if (w_finish && !r_we) begin
        if (r_owner == OWN_IF) begin
          r_if_rdata <= mem_rdata;
        end else begin
          r_d_rdata <= mem_rdata;
        end
      end
    end
  end

  assign mem_en    = (r_state == ACCESS);
  assign mem_we    = mem_en & r_we;
  assign mem_addr  = mem_en ? r_addr : '0;
  assign mem_wdata = mem_en ? r_wdata : '0;
  assign busy      = (r_state != IDLE);
  assign if_gnt    = r_if_gnt;
  assign d_gnt     = r_d_gnt;
  assign if_valid  = r_if_valid;
  assign d_valid   = r_d_valid;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3), a memory
// model per instance that returns the right byte only in the last access cycle,
// a transaction-timeline reference model compared every cycle, directed cases
// with literal expectations and a randomized phase.
module tb_mem_arbiter;

  localparam int AW   = 10;
  localparam int DW   = 8;
  localparam int SMAX = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          if_req    [2];
  logic [AW-1:0] if_addr   [2];
  logic          if_gnt    [2];
  logic          if_valid  [2];
  logic [DW-1:0] if_rdata  [2];
  logic          d_req     [2];
  logic          d_we      [2];
  logic [AW-1:0] d_addr    [2];
  logic [DW-1:0] d_wdata   [2];
  logic          d_gnt     [2];
  logic          d_valid   [2];
  logic [DW-1:0] d_rdata   [2];
  logic          mem_en    [2];
  logic          mem_we    [2];
  logic [AW-1:0] mem_addr  [2];
  logic [DW-1:0] mem_wdata [2];
  logic [DW-1:0] mem_rdata [2];
  logic          busy      [2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s u%0d @%0t: got 0x%0h, expected 0x%0h", name, k, $time, act, exp);
    end
  endtask

  // Power-up memory contents shared by the bench memory and the model.
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    if (a == 10'h004) return 8'h84;
    if (a == 10'h010) return 8'h97;
    return 8'((a * 37 + 11) ^ 8'h5A);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_u
    localparam int LAT = (g == 0) ? 1 : 3;

    mem_arbiter #(
      .ADDR_W    (AW),
      .DATA_W    (DW),
      .MEM_LAT   (LAT),
      .STARVE_MAX(SMAX)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .if_req   (if_req[g]),
      .if_addr  (if_addr[g]),
      .if_gnt   (if_gnt[g]),
      .if_valid (if_valid[g]),
      .if_rdata (if_rdata[g]),
      .d_req    (d_req[g]),
      .d_we     (d_we[g]),
      .d_addr   (d_addr[g]),
      .d_wdata  (d_wdata[g]),
      .d_gnt    (d_gnt[g]),
      .d_valid  (d_valid[g]),
      .d_rdata  (d_rdata[g]),
      .mem_en   (mem_en[g]),
      .mem_we   (mem_we[g]),
      .mem_addr (mem_addr[g]),
      .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g]),
      .busy     (busy[g])
    );

    // Memory: data is only correct in the final cycle of a read access,
    // so sampling on the wrong edge yields the inverted byte.
    bit [DW-1:0]   bmem  [1024];
    bit            bflag [1024];
    int            en_cnt;
    logic [DW-1:0] rd_val;

    assign rd_val = bflag[mem_addr[g]] ? bmem[mem_addr[g]] : init_val(mem_addr[g]);
    assign mem_rdata[g] = (mem_en[g] && en_cnt == LAT - 1) ? rd_val : ~rd_val;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) en_cnt <= 0;
      else        en_cnt <= mem_en[g] ? en_cnt + 1 : 0;
    end

    always @(posedge clk) begin
      if (mem_we[g]) begin
        bmem[mem_addr[g]]  <= mem_wdata[g];
        bflag[mem_addr[g]] <= 1'b1;
      end
    end

    // Reference model: each accepted request becomes a timeline
    // (grant at t_g, memory busy for len cycles, response at t_g+len).
    int            cyc = 0;
    bit            act = 1'b0;
    int            t_g = 0;
    int            len = 0;
    bit            own_d, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    int            starve = 0;
    logic [DW-1:0] exp_if_rd = '0;
    logic [DW-1:0] exp_d_rd = '0;
    bit [DW-1:0]   mmem  [1024];
    bit            mflag [1024];

    always @(negedge clk) begin : p_model
      bit            in_txn, in_acc, at_v, pick_if;
      logic [DW-1:0] rd;
      if (!rst_n) begin
        act = 1'b0;
        starve = 0;
        exp_if_rd = '0;
        exp_d_rd = '0;
        chk("rst_busy", g, busy[g], 0);
        chk("rst_mem_en", g, mem_en[g], 0);
        chk("rst_mem_we", g, mem_we[g], 0);
        chk("rst_mem_addr", g, mem_addr[g], 0);
        chk("rst_mem_wdata", g, mem_wdata[g], 0);
        chk("rst_gnt", g, {if_gnt[g], d_gnt[g]}, 0);
        chk("rst_valid", g, {if_valid[g], d_valid[g]}, 0);
        chk("rst_rdata", g, {if_rdata[g], d_rdata[g]}, 0);
      end else begin
        in_txn = act && cyc >= t_g && cyc <= t_g + len;
        in_acc = act && cyc >= t_g && cyc < t_g + len;
        at_v   = act && cyc == t_g + len;
        if (at_v && !m_we) begin
          rd = mflag[m_addr] ? mmem[m_addr] : init_val(m_addr);
          if (own_d) exp_d_rd = rd;
          else       exp_if_rd = rd;
        end
        chk("busy", g, busy[g], in_txn);
        chk("mem_en", g, mem_en[g], in_acc);
        chk("mem_we", g, mem_we[g], in_acc && m_we);
        chk("mem_addr", g, mem_addr[g], in_acc ? m_addr : '0);
        if (!in_acc || m_we) chk("mem_wdata", g, mem_wdata[g], in_acc ? m_wdata : '0);
        chk("if_gnt", g, if_gnt[g], in_acc && cyc == t_g && !own_d);
        chk("d_gnt", g, d_gnt[g], in_acc && cyc == t_g && own_d);
        chk("if_valid", g, if_valid[g], at_v && !own_d);
        chk("d_valid", g, d_valid[g], at_v && own_d);
        chk("if_rdata", g, if_rdata[g], exp_if_rd);
        chk("d_rdata", g, d_rdata[g], exp_d_rd);
        if (!in_txn && (if_req[g] || d_req[g])) begin
          pick_if = if_req[g] && (!d_req[g] || starve == SMAX);
          if (pick_if) starve = 0;
          else if (if_req[g] && starve < SMAX) starve++;
          act     = 1'b1;
          t_g     = cyc + 1;
          own_d   = !pick_if;
          m_addr  = pick_if ? if_addr[g] : d_addr[g];
          m_we    = !pick_if && d_we[g];
          m_wdata = d_wdata[g];
          len     = m_we ? 1 : LAT;
          if (m_we) begin
            mmem[m_addr]  = m_wdata;
            mflag[m_addr] = 1'b1;
          end
        end
      end
      cyc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin : p_watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin : p_main
    bit exp_ord [6] = '{0, 0, 1, 0, 0, 1};
    bit ord [6];
    int n;
    int en_count;
    for (int k = 0; k < 2; k++) begin
      if_req[k] = 1'b0; if_addr[k] = '0;
      d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
    end
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    at_neg();
    chk("post_rst_busy", 0, busy[0], 0);
    chk("post_rst_if_rdata", 1, if_rdata[1], 0);

    // Single fetch, MEM_LAT=1.
    step(); if_req[0] = 1'b1; if_addr[0] = 10'h004;
    at_neg(); chk("t1_gnt_N", 0, if_gnt[0], 0);
    step(); if_req[0] = 1'b0;
    at_neg(); chk("t1_gnt", 0, if_gnt[0], 1); chk("t1_addr", 0, mem_addr[0], 10'h004);
    step();
    at_neg(); chk("t1_valid", 0, if_valid[0], 1); chk("t1_rdata", 0, if_rdata[0], 8'h84);
    step();
    at_neg(); chk("t1_idle", 0, busy[0], 0);

    // Store then read back.
    step(); d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 10'h3FF; d_wdata[0] = 8'hA5;
    step(); d_req[0] = 1'b0; d_we[0] = 1'b0;
    at_neg();
    chk("t2_gnt", 0, d_gnt[0], 1); chk("t2_we", 0, mem_we[0], 1);
    chk("t2_addr", 0, mem_addr[0], 10'h3FF); chk("t2_wdata", 0, mem_wdata[0], 8'hA5);
    step();
    at_neg(); chk("t2_we_off", 0, mem_we[0], 0); chk("t2_valid", 0, d_valid[0], 1);
    step();
    step(); d_req[0] = 1'b1; d_addr[0] = 10'h3FF;
    step(); d_req[0] = 1'b0;
    step();
    at_neg(); chk("t2_rb_valid", 0, d_valid[0], 1); chk("t2_rb_data", 0, d_rdata[0], 8'hA5);

    // Both held: starvation guard order.
    step(); step();
    if_req[0] = 1'b1; if_addr[0] = 10'h100; d_req[0] = 1'b1; d_addr[0] = 10'h200;
    n = 0;
    for (int i = 0; i < 60 && n < 6; i++) begin
      at_neg();
      chk("t3_single_gnt", 0, if_gnt[0] && d_gnt[0], 0);
      if (if_gnt[0] || d_gnt[0]) begin
        ord[n] = if_gnt[0];
        n++;
      end
      step();
    end
    if_req[0] = 1'b0; d_req[0] = 1'b0;
    chk("t3_count", 0, n, 6);
    for (int i = 0; i < 6; i++) chk("t3_order", 0, ord[i], exp_ord[i]);
    repeat (4) step();

    // MEM_LAT=3 load.
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 10'h010;
    en_count = 0;
    at_neg(); en_count += int'(mem_en[1]);
    for (int i = 1; i <= 5; i++) begin
      step();
      if (i == 1) d_req[1] = 1'b0;
      at_neg();
      en_count += int'(mem_en[1]);
      if (i == 4) begin
        chk("t4_valid", 1, d_valid[1], 1); chk("t4_rdata", 1, d_rdata[1], 8'h97);
      end else begin
        chk("t4_no_valid", 1, d_valid[1], 0);
      end
    end
    chk("t4_en_cycles", 1, en_count, 3);

    // Address change after grant must not affect the access.
    step(); if_req[1] = 1'b1; if_addr[1] = 10'h004;
    step(); if_req[1] = 1'b0;
    at_neg(); chk("t6_gnt", 1, if_gnt[1], 1); chk("t6_addr1", 1, mem_addr[1], 10'h004);
    step(); if_addr[1] = 10'h007;
    at_neg(); chk("t6_addr2", 1, mem_addr[1], 10'h004);
    step();
    at_neg(); chk("t6_addr3", 1, mem_addr[1], 10'h004);
    step();
    at_neg(); chk("t6_valid", 1, if_valid[1], 1); chk("t6_rdata", 1, if_rdata[1], 8'h84);
    step(); step();

    // Reset in the second ACCESS cycle of a MEM_LAT=3 fetch.
    if_req[1] = 1'b1; if_addr[1] = 10'h020;
    step(); if_req[1] = 1'b0;
    at_neg(); chk("t5_gnt", 1, if_gnt[1], 1);
    step(); rst_n = 1'b0;
    #1;
    chk("t5_busy", 1, busy[1], 0); chk("t5_en", 1, mem_en[1], 0);
    chk("t5_addr", 1, mem_addr[1], 0); chk("t5_rdata", 1, if_rdata[1], 0);
    step(); step(); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      at_neg(); chk("t5_no_valid", 1, if_valid[1], 0);
      step();
    end
    if_req[1] = 1'b1; if_addr[1] = 10'h004;
    step(); if_req[1] = 1'b0;
    step(); step(); step();
    at_neg(); chk("t5_valid", 1, if_valid[1], 1); chk("t5_rdata2", 1, if_rdata[1], 8'h84);
    step(); step();

    // Randomized traffic, protocol-compliant requesters.
    repeat (3000) begin
      step();
      for (int k = 0; k < 2; k++) begin
        if (!if_req[k] || if_gnt[k]) begin
          if_req[k]  = ($urandom_range(0, 2) != 0);
          if_addr[k] = AW'($urandom_range(0, 31));
        end
        if (!d_req[k] || d_gnt[k]) begin
          d_req[k]   = ($urandom_range(0, 1) != 0);
          d_we[k]    = ($urandom_range(0, 1) != 0);
          d_addr[k]  = AW'($urandom_range(0, 31));
          d_wdata[k] = DW'($urandom);
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      if_req[k] = 1'b0; d_req[k] = 1'b0;
    end
    repeat (12) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
